// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl
// Main control FSM for a multicycle MIPS datapath. Walks each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK based on the IR opcode and
// drives every datapath enable and mux select. Memory states stretch on
// mem_ready. A bounded wait counter aborts a hung access back to FETCH.
module multicycle_main_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [3:0] state,
  output logic       ill_op,
  output logic       mem_err
);

  // State encodings. These are also the debug codes driven on the state port.
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  // Supported opcodes.
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // The wait counter is compared against TIMEOUT at CNT_W bits.
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_op_q, ill_op_d;
  logic             mem_err_q, mem_err_d;

  // Next-state, wait-counter and error-pulse logic.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. A path
    // that leaves one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = '0;
    ill_op_d  = 1'b0;
    mem_err_d = 1'b0;

    unique case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          // Access completes. This includes the cycle where the counter has
          // just reached TIMEOUT, because a late ready still wins.
          unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if (cnt_q == TIMEOUT_C) begin
          // Hung access: abandon the instruction without its write-back or store.
          state_d   = S_FETCH;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d  = S_FETCH;
            ill_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      // An unused code recovers to FETCH.
      default:  state_d = S_FETCH;
    endcase
  end

  // State, counter and error-pulse registers with async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: use non-blocking assignments here so that every flop samples the
    // values from before the clock edge, regardless of statement order.
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      ill_op_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ill_op_q  <= ill_op_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Moore output decode. The FETCH IR/PC loads are qualified by mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign ill_op  = ill_op_q;
  assign mem_err = mem_err_q;

endmodule
